user_sync_fifo_ctrl: RTL and testbench

USER_SYNC_FIFO_CTRL -- requirements
Module: user_sync_fifo_ctrl

---
 rtl/user_sync_fifo_ctrl.sv | 98 +++++++++
 tb/tb_user_sync_fifo_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/user_sync_fifo_ctrl.sv
// Synchronous FIFO controller driving an external dual-port RAM with a registered read port.
// Optional sticky overflow/underflow flags are built when USER_FIFO_ERR_FLAG_EN is defined.
module user_sync_fifo_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 9,
  parameter int AFULL_THRESH  = 2**ADDR_WIDTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam logic [ADDR_WIDTH:0] ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);

  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr, count_nxt;
  logic                wr_acc, rd_acc;

  assign full      = (count == DEPTH);
  assign empty     = (count == '0);
  assign wr_acc    = wr_en & ~full;
  assign rd_acc    = rd_en & ~empty;

  assign ram_we    = wr_acc;
  assign ram_waddr = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_wdata = wr_data;
  assign ram_re    = rd_acc;
  assign ram_raddr = rd_ptr[ADDR_WIDTH-1:0];
  assign rd_data   = ram_rdata;

  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + ONE;
      2'b01:   count_nxt = count - ONE;
      default: count_nxt = count;
    endcase
  end

  // Threshold flags are computed from the next count so they land on the same edge as count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      rd_valid     <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rd_acc) rd_ptr <= rd_ptr + ONE;
      count        <= count_nxt;
      rd_valid     <= rd_acc;
      almost_full  <= (32'(count_nxt) >= 32'(AFULL_THRESH));
      almost_empty <= (32'(count_nxt) <= 32'(AEMPTY_THRESH));
    end
  end

`ifdef USER_FIFO_ERR_FLAG_EN
  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en & full)  overflow  <= 1'b1;
      else if (err_clr)  overflow  <= 1'b0;
      if (rd_en & empty) underflow <= 1'b1;
      else if (err_clr)  underflow <= 1'b0;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_user_sync_fifo_ctrl.sv
// Bench for user_sync_fifo_ctrl: queue-based reference model checked every cycle, a RAM model
// with registered read, and directed scenarios with literal expectations.
module tb_user_sync_fifo_ctrl;
  localparam int DW = 8, AW = 9, DEPTH = 512;

  logic clk = 1'b0, rst_n = 1'b0;
  logic wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] rd_data, ram_wdata, ram_rdata;
  logic rd_valid, full, empty, almost_full, almost_empty, overflow, underflow, ram_we, ram_re;
  logic [AW:0] count;
  logic [AW-1:0] ram_waddr, ram_raddr;

  int checks = 0, errors = 0;

  user_sync_fifo_ctrl dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // External RAM with a registered read port
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_raddr];
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words plus totals of accepted writes/reads
  logic [DW-1:0] q[$];
  int unsigned n_wr, n_rd;
  bit m_rv, m_ovf, m_udf;
  logic [DW-1:0] m_rd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete(); n_wr = 0; n_rd = 0; m_rv = 0; m_ovf = 0; m_udf = 0;
    end else begin
      bit was_full, was_empty;
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      m_rv = rd_en && !was_empty;
      if (m_rv) begin m_rd = q.pop_front(); n_rd++; end
      if (wr_en && !was_full) begin q.push_back(wr_data); n_wr++; end
`ifdef USER_FIFO_ERR_FLAG_EN
      if (wr_en && was_full) m_ovf = 1; else if (err_clr) m_ovf = 0;
      if (rd_en && was_empty) m_udf = 1; else if (err_clr) m_udf = 0;
`endif
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      int sz;
      sz = q.size();
      chk("count", count, sz);
      chk("full", full, sz == DEPTH);
      chk("empty", empty, sz == 0);
      chk("almost_full", almost_full, sz >= DEPTH - 4);
      chk("almost_empty", almost_empty, sz <= 4);
      chk("rd_valid", rd_valid, m_rv);
      if (m_rv) chk("rd_data", rd_data, m_rd);
      chk("ram_we", ram_we, wr_en && sz != DEPTH);
      chk("ram_re", ram_re, rd_en && sz != 0);
      if (ram_we) chk("ram_waddr", ram_waddr, n_wr % DEPTH);
      if (ram_re) chk("ram_raddr", ram_raddr, n_rd % DEPTH);
      chk("overflow", overflow, m_ovf);
      chk("underflow", underflow, m_udf);
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic fill(input bit thr_checks);
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1; wr_data = DW'(i);
      step();
      if (thr_checks) begin
        if (i == 3)   chk("lit_ae_at4", almost_empty, 1);
        if (i == 4)   chk("lit_ae_at5", almost_empty, 0);
        if (i == 506) chk("lit_af_at507", almost_full, 0);
        if (i == 507) chk("lit_af_at508", almost_full, 1);
      end
    end
    wr_en = 0;
  endtask

  bit ovf_exp;
  int budget;

  initial begin
`ifdef USER_FIFO_ERR_FLAG_EN
    ovf_exp = 1;
`else
    ovf_exp = 0;
`endif
    #12;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    rst_n = 1;
    step();

    // Fill, then one refused write
    fill(1);
    chk("lit_full", full, 1);
    chk("lit_count512", count, 512);
    wr_en = 1; #1;
    chk("lit_we_when_full", ram_we, 0);
    step(); wr_en = 0;
    chk("lit_overflow", overflow, ovf_exp);

    // Drain back-to-back
    rd_en = 1;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      chk("lit_drain_valid", rd_valid, 1);
      chk("lit_drain_data", rd_data, i % 256);
      if (i == DEPTH - 1) rd_en = 0;
    end
    step();
    chk("lit_drain_empty", empty, 1);
    chk("lit_valid_after", rd_valid, 0);
    rd_en = 1; #1;
    chk("lit_re_when_empty", ram_re, 0);
    step(); rd_en = 0;
    chk("lit_underflow", underflow, ovf_exp);

    // Clear with a simultaneous new underflow: set wins
    rd_en = 1; err_clr = 1;
    step(); rd_en = 0;
    chk("lit_udf_set_wins", underflow, ovf_exp);
    chk("lit_ovf_cleared", overflow, 0);
    step(); err_clr = 0;
    chk("lit_udf_cleared", underflow, 0);

    // Simultaneous access when full, then when empty
    fill(0);
    wr_en = 1; rd_en = 1; #1;
    chk("lit_full_both_we", ram_we, 0);
    chk("lit_full_both_re", ram_re, 1);
    step(); wr_en = 0; rd_en = 0;
    chk("lit_count511", count, 511);
    rd_en = 1;
    for (int i = 0; i < DEPTH - 1; i++) step();
    rd_en = 0;
    chk("lit_count0", count, 0);
    wr_en = 1; rd_en = 1; wr_data = 8'hA5; #1;
    chk("lit_empty_both_we", ram_we, 1);
    chk("lit_empty_both_re", ram_re, 0);
    step(); wr_en = 0; rd_en = 0;
    chk("lit_count1", count, 1);
    chk("lit_no_writethrough", rd_valid, 0);
    rd_en = 1; step(); rd_en = 0;
    chk("lit_a5", rd_data, 8'hA5);
    step();
    err_clr = 1; step(); err_clr = 0;

    // Random stream of 2000 words
    begin
      int sent = 0;
      budget = 0;
      while ((sent < 2000 || q.size() != 0) && budget < 20000) begin
        wr_en = (sent < 2000) && ($urandom_range(0, 1) == 1);
        rd_en = ($urandom_range(0, 1) == 1);
        wr_data = DW'($urandom);
        if (wr_en && q.size() != DEPTH) sent++;
        step();
        budget++;
      end
      wr_en = 0; rd_en = 0;
      chk("stream_done", (budget < 20000) ? 1 : 0, 1);
      step();
      chk("stream_totals", n_wr - n_rd, 0);
    end

    // Reset with a read in flight
    for (int i = 0; i < 10; i++) begin wr_en = 1; wr_data = DW'(i + 100); step(); end
    wr_en = 0; rd_en = 1;
    step();
    #1; rst_n = 0; rd_en = 0; #1;
    chk("lit_rst_count", count, 0);
    chk("lit_rst_empty", empty, 1);
    chk("lit_rst_valid", rd_valid, 0);
    step();
    rst_n = 1;
    step(); step();
    chk("lit_no_valid_after_rst", rd_valid, 0);
    wr_en = 1; wr_data = 8'h3C; step(); wr_en = 0;
    rd_en = 1; step(); rd_en = 0;
    chk("lit_post_rst_valid", rd_valid, 1);
    chk("lit_post_rst_data", rd_data, 8'h3C);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
